// File: rtl/down_counter_pkg.sv
// Shared definitions for the loadable down-counter: state encoding and default width.
package down_counter_pkg;

    localparam int DEFAULT_WIDTH = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        RUN     = 2'b01,
        EXPIRED = 2'b10
    } state_e;

endpackage : down_counter_pkg

// File: rtl/down_counter.sv
// Loadable down-counter with one-cycle terminal-count pulse, sticky expiry
// status and optional auto-reload from the last loaded value.
module down_counter
    import down_counter_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             enable,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             auto_reload,
    output logic [WIDTH-1:0] counter_out,
    output logic             tc_pulse,
    output logic             done,
    output logic             busy
);

    state_e           r_state;
    logic [WIDTH-1:0] r_count;
    logic [WIDTH-1:0] r_reload;
    logic             r_tc_pulse;

    state_e           w_state_nxt;
    logic [WIDTH-1:0] w_count_nxt;
    logic [WIDTH-1:0] w_reload_nxt;
    logic             w_tc_pulse_nxt;

    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        w_state_nxt    = r_state;
        w_count_nxt    = r_count;
        w_reload_nxt   = r_reload;
        w_tc_pulse_nxt = 1'b0;

        if (load) begin
            w_count_nxt  = load_value;
            w_reload_nxt = load_value;
            w_state_nxt  = (load_value != '0) ? RUN : IDLE;
        end else if (r_state == RUN && enable) begin
            // Terminal detection at 1 keeps the count from ever wrapping below zero.
            if (r_count == WIDTH'(1)) begin
                w_tc_pulse_nxt = 1'b1;
                if (auto_reload) begin
                    w_count_nxt = r_reload;
                end else begin
                    w_count_nxt = '0;
                    w_state_nxt = EXPIRED;
                end
            end else begin
                w_count_nxt = r_count - WIDTH'(1);
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= IDLE;
            r_count    <= '0;
            r_reload   <= '0;
            r_tc_pulse <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_count    <= w_count_nxt;
            r_reload   <= w_reload_nxt;
            r_tc_pulse <= w_tc_pulse_nxt;
        end
    end

    assign counter_out = r_count;
    assign tc_pulse    = r_tc_pulse;
    assign done        = (r_state == EXPIRED);
    assign busy        = (r_state == RUN);

endmodule : down_counter

// File: tb/tb_down_counter.sv
// Directed self-checking bench for down_counter: reset, one-shot, auto-reload,
// enable gaps, load collision and load-value boundaries.
module tb_down_counter;

    localparam int WIDTH = 4;

    logic             clk;
    logic             reset_n;
    logic             enable;
    logic             load;
    logic [WIDTH-1:0] load_value;
    logic             auto_reload;
    logic [WIDTH-1:0] counter_out;
    logic             tc_pulse;
    logic             done;
    logic             busy;

    int checks   = 0;
    int failures = 0;

    down_counter #(.WIDTH(WIDTH)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .enable      (enable),
        .load        (load),
        .load_value  (load_value),
        .auto_reload (auto_reload),
        .counter_out (counter_out),
        .tc_pulse    (tc_pulse),
        .done        (done),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    // Check all four outputs against expected values.
    task automatic check_all(input string tag, input int cnt, input bit tc, input bit dn, input bit bs);
        check({tag, ".count"}, 32'(counter_out), 32'(cnt));
        check({tag, ".tc"},    32'(tc_pulse),    32'(tc));
        check({tag, ".done"},  32'(done),        32'(dn));
        check({tag, ".busy"},  32'(busy),        32'(bs));
    endtask

    // Advance one active edge; outputs are sampled on the following falling edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        reset_n     = 1'b0;
        enable      = 1'b0;
        load        = 1'b0;
        load_value  = '0;
        auto_reload = 1'b0;
        tick();
        tick();
        check_all("reset", 0, 0, 0, 0);

        reset_n = 1'b1;
        tick();
        check_all("idle_after_reset", 0, 0, 0, 0);

        // Asynchronous reset mid-count.
        load = 1'b1; load_value = 4'd5; enable = 1'b1;
        tick();
        load = 1'b0;
        tick();
        check_all("pre_reset_count", 4, 0, 0, 1);
        #2 reset_n = 1'b0;
        #1 check_all("async_reset", 0, 0, 0, 0);
        @(negedge clk);
        reset_n = 1'b1;
        tick();
        check_all("post_release_idle", 0, 0, 0, 0);

        // One-shot countdown from 5.
        load = 1'b1; load_value = 4'd5;
        tick();
        load = 1'b0;
        check_all("oneshot_load", 5, 0, 0, 1);
        for (int i = 4; i >= 1; i--) begin
            tick();
            check_all("oneshot_step", i, 0, 0, 1);
        end
        tick();
        check_all("oneshot_tc", 0, 1, 1, 0);
        tick();
        check_all("expired_hold", 0, 0, 1, 0);

        // Auto-reload from EXPIRED: load clears done.
        load = 1'b1; load_value = 4'd3; auto_reload = 1'b1;
        tick();
        load = 1'b0;
        check_all("auto3_load", 3, 0, 0, 1);
        for (int i = 1; i <= 6; i++) begin
            tick();
            check_all("auto3_step", (i % 3 == 0) ? 3 : 3 - (i % 3), (i % 3 == 0), 0, 1);
        end

        // Enable gaps: 4,3,3,3,2.
        load = 1'b1; load_value = 4'd4; auto_reload = 1'b0;
        tick();
        load = 1'b0;
        check_all("gap_load", 4, 0, 0, 1);
        enable = 1'b1; tick(); check_all("gap_en1", 3, 0, 0, 1);
        enable = 1'b0; tick(); check_all("gap_en0a", 3, 0, 0, 1);
        enable = 1'b0; tick(); check_all("gap_en0b", 3, 0, 0, 1);
        enable = 1'b1; tick(); check_all("gap_en1b", 2, 0, 0, 1);

        // Load collides with terminal decrement.
        tick();
        check_all("collide_at1", 1, 0, 0, 1);
        load = 1'b1; load_value = 4'd9;
        tick();
        load = 1'b0;
        check_all("collide_load", 9, 0, 0, 1);

        // Load of zero goes to IDLE without a pulse.
        load = 1'b1; load_value = 4'd0;
        tick();
        load = 1'b0;
        check_all("load0", 0, 0, 0, 0);
        tick();
        check_all("load0_hold", 0, 0, 0, 0);

        // Full-scale auto-reload: pulse every 15 cycles.
        load = 1'b1; load_value = 4'd15; auto_reload = 1'b1;
        tick();
        load = 1'b0;
        check_all("auto15_load", 15, 0, 0, 1);
        for (int i = 1; i <= 30; i++) begin
            tick();
            check_all("auto15_step", (i % 15 == 0) ? 15 : 15 - (i % 15), (i % 15 == 0), 0, 1);
        end

        // Auto-reload of 1: pulse every cycle.
        load = 1'b1; load_value = 4'd1;
        tick();
        load = 1'b0;
        check_all("auto1_load", 1, 0, 0, 1);
        for (int i = 0; i < 4; i++) begin
            tick();
            check_all("auto1_step", 1, 1, 0, 1);
        end
        enable = 1'b0;
        tick();
        check_all("auto1_paused", 1, 0, 0, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_down_counter
